// File: rtl/dco_trim_ctrl.sv
// Frequency-lock loop for the 13-stage trimmed DCO: counts DCO cycles per reference period and steps a 0..26 trim code.
// Optional macro DCO_BYPASS_EN adds dco_mode/ext_trim for a direct trim override.
module dco_trim_ctrl #(
  parameter int CW        = 8,
  parameter int TOL       = 1,
  parameter int LOCK_N    = 4,
  parameter int INIT_CODE = 13
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          enable,
  input  logic          ref_in,
  input  logic [CW-1:0] div,
`ifdef DCO_BYPASS_EN
  input  logic          dco_mode,
  input  logic [25:0]   ext_trim,
`endif
  output logic [25:0]   trim,
  output logic [4:0]    code,
  output logic          locked
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    MEASURE = 3'd2,
    ADJUST  = 3'd3,
    DISCARD = 3'd4
  } state_t;

  localparam int              LCW      = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic [CW:0]     TOL_W    = (CW+1)'(TOL);
  localparam logic [4:0]      INIT_C   = 5'(INIT_CODE);
  localparam logic [4:0]      MAX_CODE = 5'd26;
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_N);

  // Primary stages 0..12 fill first, then secondary stages 13..25.
  function automatic logic [25:0] expand(input logic [4:0] n);
    logic [25:0] w;
    w = 26'd0;
    for (int i = 0; i < 13; i++) begin
      w[i]      = (5'(i) < n);
      w[13 + i] = (5'(i + 13) < n);
    end
    return w;
  endfunction

  state_t         state_r;
  logic [2:0]     sync_r;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  meas_r;
  logic [LCW-1:0] lock_cnt_r;
  logic [4:0]     code_r;
  logic [25:0]    trim_r;
  logic           locked_r;

  logic           ref_edge_s;
  logic           bypass_s;
  logic           too_fast_s;
  logic           too_slow_s;
  logic [CW:0]    div_hi_s;
  logic [CW:0]    div_lo_s;
  logic [CW:0]    meas_w_s;
  logic [4:0]     code_up_s;
  logic [4:0]     code_dn_s;
  logic [LCW-1:0] lock_inc_s;

`ifdef DCO_BYPASS_EN
  assign bypass_s = dco_mode;
`else
  assign bypass_s = 1'b0;
`endif

  assign ref_edge_s = sync_r[1] & ~sync_r[2];
  assign trim       = trim_r;
  assign code       = code_r;
  assign locked     = locked_r;

  // Classify the last measurement and precompute saturating code/lock steps.
  always_comb begin
    div_hi_s = {1'b0, div} + TOL_W;
    if ({1'b0, div} > TOL_W) begin
      div_lo_s = {1'b0, div} - TOL_W;
    end else begin
      div_lo_s = {(CW+1){1'b0}};
    end
    meas_w_s   = {1'b0, meas_r};
    too_fast_s = (meas_r == CNT_MAX) || (meas_w_s > div_hi_s);
    too_slow_s = !too_fast_s && (meas_w_s < div_lo_s);
    if (code_r == MAX_CODE) begin
      code_up_s = code_r;
    end else begin
      code_up_s = code_r + 5'd1;
    end
    if (code_r == 5'd0) begin
      code_dn_s = code_r;
    end else begin
      code_dn_s = code_r - 5'd1;
    end
    if (lock_cnt_r == LOCK_MAX) begin
      lock_inc_s = lock_cnt_r;
    end else begin
      lock_inc_s = lock_cnt_r + LCW'(1);
    end
  end

  // Three-flop synchronizer for the asynchronous reference.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], ref_in};
    end
  end

  // Saturating period counter; restarts at 1 on each reference edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_r  <= {CW{1'b0}};
      meas_r <= {CW{1'b0}};
    end else if (state_r == IDLE) begin
      cnt_r <= {CW{1'b0}};
    end else if (ref_edge_s) begin
      meas_r <= cnt_r;
      cnt_r  <= CW'(1);
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Loop FSM: a code change invalidates the period in flight, so it is discarded.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r    <= IDLE;
      code_r     <= INIT_C;
      locked_r   <= 1'b0;
      lock_cnt_r <= {LCW{1'b0}};
    end else if (bypass_s || !enable) begin
      state_r    <= IDLE;
      code_r     <= INIT_C;
      locked_r   <= 1'b0;
      lock_cnt_r <= {LCW{1'b0}};
    end else begin
      case (state_r)
        IDLE: state_r <= SYNC;
        SYNC: begin
          if (ref_edge_s) state_r <= MEASURE;
        end
        MEASURE: begin
          if (ref_edge_s) begin
            state_r <= ADJUST;
          end else if (cnt_r == CNT_MAX) begin
            locked_r   <= 1'b0;
            lock_cnt_r <= {LCW{1'b0}};
          end
        end
        ADJUST: begin
          if (too_fast_s || too_slow_s) begin
            code_r     <= too_fast_s ? code_up_s : code_dn_s;
            locked_r   <= 1'b0;
            lock_cnt_r <= {LCW{1'b0}};
            if ((too_fast_s ? code_up_s : code_dn_s) != code_r) begin
              state_r <= DISCARD;
            end else begin
              state_r <= MEASURE;
            end
          end else begin
            lock_cnt_r <= lock_inc_s;
            locked_r   <= (lock_inc_s == LOCK_MAX);
            state_r    <= MEASURE;
          end
        end
        DISCARD: begin
          if (ref_edge_s) state_r <= MEASURE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Trim word follows the code one cycle later.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      trim_r <= expand(INIT_C);
    end else begin
`ifdef DCO_BYPASS_EN
      trim_r <= dco_mode ? ext_trim : expand(code_r);
`else
      trim_r <= expand(code_r);
`endif
    end
  end

endmodule

// File: tb/tb_dco_trim_ctrl.sv
// Self-checking bench for dco_trim_ctrl: table of reference periods plus hand-written corner sequences.
// Each ref period starts with a rising edge; expectations are derived from the spec's loop rules.
module tb_dco_trim_ctrl;

  logic        clock = 1'b0;
  logic        resetb;
  logic        enable;
  logic        ref_in;
  logic [7:0]  div;
  logic [25:0] trim;
  logic [4:0]  code;
  logic        locked;
`ifdef DCO_BYPASS_EN
  logic        dco_mode;
  logic [25:0] ext_trim;
`endif

  always #5 clock = ~clock;

  dco_trim_ctrl dut (
    .clock    (clock),
    .resetb   (resetb),
    .enable   (enable),
    .ref_in   (ref_in),
    .div      (div),
`ifdef DCO_BYPASS_EN
    .dco_mode (dco_mode),
    .ext_trim (ext_trim),
`endif
    .trim     (trim),
    .code     (code),
    .locked   (locked)
  );

  typedef struct {
    logic [7:0] div;
    int         period;
    logic [4:0] code;
    logic       locked;
  } vec_t;

  typedef struct {
    logic [4:0]  code;
    logic        locked;
    logic [25:0] trim;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Thermometer of n ones: independent formulation of the code expansion.
  function automatic logic [25:0] therm(input int n);
    logic [26:0] t;
    t = (27'd1 << n) - 27'd1;
    return t[25:0];
  endfunction

  task automatic cmp(input string tag, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_raw(input string tag, input logic [4:0] c, input logic l, input logic [25:0] t);
    exp_t e;
    e.code = c; e.locked = l; e.trim = t; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic expect_code(input string tag, input logic [4:0] c, input logic l);
    expect_raw(tag, c, l, therm(int'(c)));
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      cmp({e.tag, ".code"}, {21'd0, code}, {21'd0, e.code});
      cmp({e.tag, ".locked"}, {25'd0, locked}, {25'd0, e.locked});
      cmp({e.tag, ".trim"}, trim, e.trim);
    end
  endtask

  // Drive count reference periods: high for the first half, low for the rest.
  task automatic ref_periods(input logic [7:0] d, input int period, input int count);
    div = d;
    for (int k = 0; k < count; k++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clock);
        ref_in = (c < period / 2);
      end
    end
  endtask

  initial begin
    vec_t tbl[18];
    resetb = 1'b0;
    enable = 1'b0;
    ref_in = 1'b0;
    div    = 8'd20;
`ifdef DCO_BYPASS_EN
    dco_mode = 1'b0;
    ext_trim = 26'd0;
`endif

    tbl[0]  = '{8'd20, 30, 5'd13, 1'b0};
    tbl[1]  = '{8'd20, 30, 5'd14, 1'b0};
    tbl[2]  = '{8'd20, 30, 5'd14, 1'b0};
    tbl[3]  = '{8'd20, 30, 5'd15, 1'b0};
    tbl[4]  = '{8'd20, 30, 5'd15, 1'b0};
    tbl[5]  = '{8'd20, 20, 5'd16, 1'b0};
    tbl[6]  = '{8'd20, 20, 5'd16, 1'b0};
    tbl[7]  = '{8'd20, 20, 5'd16, 1'b0};
    tbl[8]  = '{8'd20, 20, 5'd16, 1'b0};
    tbl[9]  = '{8'd20, 20, 5'd16, 1'b0};
    tbl[10] = '{8'd20, 20, 5'd16, 1'b1};
    tbl[11] = '{8'd20, 23, 5'd16, 1'b1};
    tbl[12] = '{8'd20, 20, 5'd17, 1'b0};
    tbl[13] = '{8'd20, 20, 5'd17, 1'b0};
    tbl[14] = '{8'd20, 20, 5'd17, 1'b0};
    tbl[15] = '{8'd20, 20, 5'd17, 1'b0};
    tbl[16] = '{8'd20, 20, 5'd17, 1'b0};
    tbl[17] = '{8'd20, 20, 5'd17, 1'b1};

    repeat (3) @(negedge clock);
    expect_code("reset", 5'd13, 1'b0);
    check_out();
    cmp("reset.trim_const", trim, 26'h0001FFF);

    resetb = 1'b1;
    ref_periods(8'd20, 20, 3);
    expect_code("idle_hold", 5'd13, 1'b0);
    check_out();

    enable = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 18; i++) begin
      expect_code($sformatf("row%0d", i + 1), tbl[i].code, tbl[i].locked);
      ref_periods(tbl[i].div, tbl[i].period, 1);
      check_out();
    end

    // Reference stuck low: counter saturates, lock drops, code holds.
    expect_code("stuck_low", 5'd17, 1'b0);
    repeat (300) @(negedge clock);
    check_out();

    // Saturated count is too fast even when it sits inside the window.
    expect_code("sat_is_fast", 5'd18, 1'b0);
    ref_periods(8'd254, 20, 1);
    check_out();

    expect_code("slow_floor", 5'd0, 1'b0);
    ref_periods(8'd200, 5, 50);
    check_out();
    cmp("slow_floor.trim_zero", trim, 26'h0000000);

    expect_code("div0_ceiling", 5'd26, 1'b0);
    ref_periods(8'd0, 30, 60);
    check_out();
    cmp("div0_ceiling.trim_ones", trim, 26'h3FFFFFF);

    expect_code("p250_hold", 5'd26, 1'b0);
    ref_periods(8'd20, 250, 2);
    check_out();

    // Drop enable while measuring.
    ref_periods(8'd20, 10, 1);
    repeat (5) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    cmp("en_drop.code", {21'd0, code}, 26'd13);
    cmp("en_drop.locked", {25'd0, locked}, 26'd0);
    cmp("en_drop.trim_lag", trim, therm(26));
    @(negedge clock);
    expect_code("en_drop.settled", 5'd13, 1'b0);
    check_out();

    // Restart, step once, then assert reset asynchronously mid-cycle.
    enable = 1'b1;
    repeat (2) @(negedge clock);
    expect_code("restart", 5'd14, 1'b0);
    ref_periods(8'd20, 30, 2);
    check_out();
    #1;
    resetb = 1'b0;
    #1;
    expect_code("async_reset", 5'd13, 1'b0);
    check_out();
    @(negedge clock);
    resetb = 1'b1;

`ifdef DCO_BYPASS_EN
    dco_mode = 1'b1;
    ext_trim = 26'h155AAAA;
    @(negedge clock);
    expect_raw("bypass", 5'd13, 1'b0, 26'h155AAAA);
    check_out();
    expect_raw("bypass_hold", 5'd13, 1'b0, 26'h155AAAA);
    ref_periods(8'd20, 20, 2);
    check_out();
    dco_mode = 1'b0;
    @(negedge clock);
    expect_code("bypass_release", 5'd13, 1'b0);
    check_out();
    expect_code("bypass_relock", 5'd13, 1'b1);
    ref_periods(8'd20, 20, 6);
    check_out();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
